// File: rtl/bldc_encoder_sampler_if.sv
// Sampler bus: encoder count in, sampled delta/seq out with valid/ready handshake and overrun flag.
interface bldc_encoder_sampler_if #(
  parameter int unsigned COUNTER_WIDTH = 15
);
  logic                     enable;
  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] delta;
  logic [7:0]               seq;
  logic                     valid;
  logic                     ready;
  logic                     overrun;
  logic                     overrun_clr;

  modport master (
    input  enable, count, ready, overrun_clr,
    output delta, seq, valid, overrun
  );

  modport slave (
    output enable, count, ready, overrun_clr,
    input  delta, seq, valid, overrun
  );
endinterface

// File: rtl/bldc_encoder_sampler.sv
// Periodically samples a free-running encoder count and presents the per-period delta with a sequence number.
// Optional sticky lost-sample flag enabled by defining BLDC_ENCODER_SAMPLER_OVERRUN_EN.
module bldc_encoder_sampler #(
  parameter int unsigned COUNTER_WIDTH = 15,
  parameter int unsigned SAMPLE_PERIOD = 18432
) (
  input logic                    clk,
  input logic                    reset,
  bldc_encoder_sampler_if.master bus
);
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned SEQ_W   = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state;
  logic [TIMER_W-1:0]       timer;
  logic [COUNTER_WIDTH-1:0] prev_count;
  logic [COUNTER_WIDTH-1:0] delta_q;
  logic [SEQ_W-1:0]         seq_q;
  logic                     valid_q;
  logic                     sample_c;
  logic                     transfer_c;

  assign sample_c   = (state == RUN) && (timer == TIMER_LAST);
  assign transfer_c = valid_q && bus.ready;

  // State follows enable one cycle late; IDLE keeps the reference count tracking the input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      prev_count <= '0;
      delta_q    <= '0;
      seq_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state <= bus.enable ? RUN : IDLE;
      if (state == IDLE) begin
        timer      <= '0;
        prev_count <= bus.count;
      end else if (sample_c) begin
        timer      <= '0;
        delta_q    <= bus.count - prev_count;
        prev_count <= bus.count;
        seq_q      <= seq_q + SEQ_W'(1);
      end else begin
        timer <= timer + TIMER_W'(1);
      end

      // A new sample always wins over a consumption in the same cycle.
      if (sample_c) begin
        valid_q <= 1'b1;
      end else if (transfer_c) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.delta = delta_q;
  assign bus.seq   = seq_q;
  assign bus.valid = valid_q;

`ifdef BLDC_ENCODER_SAMPLER_OVERRUN_EN
  logic overrun_q;

  // Set when an unconsumed sample is overwritten; a new set beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (sample_c && valid_q && !bus.ready) begin
      overrun_q <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;
`else
  logic unused_overrun_clr;

  assign unused_overrun_clr = bus.overrun_clr;
  assign bus.overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_bldc_encoder_sampler.sv
// Bench for bldc_encoder_sampler: vector table, directed corner sequences and a randomized run against a reference model.
module tb_bldc_encoder_sampler;
  localparam int unsigned W   = 15;
  localparam int unsigned P   = 4;
  localparam int          MOD = 1 << W;
`ifdef BLDC_ENCODER_SAMPLER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  bldc_encoder_sampler_if #(.COUNTER_WIDTH(W)) bus ();

  bldc_encoder_sampler #(.COUNTER_WIDTH(W), .SAMPLE_PERIOD(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: samples fall every P-th cycle of an unbroken enabled run.
  bit       m_en_q;
  int       m_run_len;
  int       m_ref;
  int       m_delta;
  int       m_seq;
  bit       m_valid;
  bit       m_ovr;

  task automatic model_reset();
    m_en_q = 0; m_run_len = 0; m_ref = 0; m_delta = 0; m_seq = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit en, input int cnt, input bit rdy, input bit clr);
    bit ev;
    bit xfer;
    ev   = m_en_q && ((m_run_len % P) == P - 1);
    xfer = m_valid && rdy;
    m_ovr = OVR_EN && ((ev && m_valid && !rdy) || (m_ovr && !clr));
    if (!m_en_q) begin
      m_ref     = cnt;
      m_run_len = 0;
    end else begin
      if (ev) begin
        m_delta = (cnt - m_ref + MOD) % MOD;
        m_ref   = cnt;
        m_seq   = (m_seq + 1) % 256;
      end
      m_run_len++;
    end
    if (ev) m_valid = 1;
    else if (xfer) m_valid = 0;
    m_en_q = en;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("mdl_delta",   32'(bus.delta),   32'(m_delta));
    check("mdl_seq",     32'(bus.seq),     32'(m_seq));
    check("mdl_valid",   32'(bus.valid),   32'(m_valid));
    check("mdl_overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic cycle(input logic en, input logic [W-1:0] cnt, input logic rdy, input logic clr);
    bus.enable      = en;
    bus.count       = cnt;
    bus.ready       = rdy;
    bus.overrun_clr = clr;
    @(posedge clk);
    model_step(en, int'(cnt), rdy, clr);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] count;
    logic         ready;
    logic         clr;
    logic [W-1:0] exp_delta;
    logic [7:0]   exp_seq;
    logic         exp_ovr;
  } vec_t;

  vec_t         tbl [8];
  logic [W-1:0] cnt_v;
  int           k;

  initial begin
    tbl[0] = '{15'h0010, 1'b1, 1'b0, 15'h0000, 8'd1, 1'b0};
    tbl[1] = '{15'h0015, 1'b1, 1'b0, 15'h0005, 8'd2, 1'b0};
    tbl[2] = '{15'h7FFE, 1'b1, 1'b0, 15'h7FE9, 8'd3, 1'b0};
    tbl[3] = '{15'h0003, 1'b1, 1'b0, 15'h0005, 8'd4, 1'b0};
    tbl[4] = '{15'h7FFD, 1'b1, 1'b0, 15'h7FFA, 8'd5, 1'b0};
    tbl[5] = '{15'h0100, 1'b0, 1'b0, 15'h0103, 8'd6, 1'b1};
    tbl[6] = '{15'h0102, 1'b0, 1'b0, 15'h0002, 8'd7, 1'b1};
    tbl[7] = '{15'h0102, 1'b1, 1'b1, 15'h0000, 8'd8, 1'b0};

    reset = 1'b0;
    bus.enable = 1'b0; bus.count = '0; bus.ready = 1'b0; bus.overrun_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_delta",   32'(bus.delta),   32'h0);
    check("rst_seq",     32'(bus.seq),     32'h0);
    check("rst_valid",   32'(bus.valid),   32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    #4 reset = 1'b1;

    // Table: arm with the first count, then one sample period per record.
    cycle(1'b1, 15'h0010, 1'b1, 1'b0);
    check("arm_valid", 32'(bus.valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < int'(P); c++) begin
        cycle(1'b1, tbl[i].count, tbl[i].ready, tbl[i].clr);
        if (c == 0 && i > 0) check("tbl_mid_valid", 32'(bus.valid), tbl[i].ready ? 32'h0 : 32'h1);
        if (c == 1 && i > 0) check("tbl_hold_seq", 32'(bus.seq), 32'(tbl[i-1].exp_seq));
      end
      check("tbl_delta",   32'(bus.delta),   32'(tbl[i].exp_delta));
      check("tbl_seq",     32'(bus.seq),     32'(tbl[i].exp_seq));
      check("tbl_valid",   32'(bus.valid),   32'h1);
      check("tbl_overrun", 32'(bus.overrun), 32'(OVR_EN && tbl[i].exp_ovr));
    end

    // Ready rises exactly on the sample-event cycle.
    for (int c = 0; c < int'(P) - 1; c++) begin
      cycle(1'b1, 15'h0110, 1'b0, 1'b0);
      check("s4_valid_hold", 32'(bus.valid), 32'h1);
    end
    cycle(1'b1, 15'h0110, 1'b1, 1'b0);
    check("s4_valid",   32'(bus.valid),   32'h1);
    check("s4_seq",     32'(bus.seq),     32'd9);
    check("s4_delta",   32'(bus.delta),   32'h000E);
    check("s4_overrun", 32'(bus.overrun), 32'h0);

    // Enable dropped at timer 2, count moves +9 while idle, then re-enabled.
    cycle(1'b1, 15'h0110, 1'b1, 1'b0);
    check("s5_consumed", 32'(bus.valid), 32'h0);
    cycle(1'b1, 15'h0110, 1'b0, 1'b0);
    cycle(1'b0, 15'h0110, 1'b0, 1'b0);
    cycle(1'b0, 15'h0119, 1'b0, 1'b0);
    cycle(1'b1, 15'h0119, 1'b0, 1'b0);
    check("s5_no_sample_valid", 32'(bus.valid), 32'h0);
    check("s5_no_sample_seq",   32'(bus.seq),   32'd9);
    for (int c = 0; c < int'(P) - 1; c++) begin
      cycle(1'b1, 15'h0120, 1'b0, 1'b0);
      check("s5_wait_valid", 32'(bus.valid), 32'h0);
    end
    cycle(1'b1, 15'h0120, 1'b0, 1'b0);
    check("s5_valid", 32'(bus.valid), 32'h1);
    check("s5_delta", 32'(bus.delta), 32'h0007);
    check("s5_seq",   32'(bus.seq),   32'd10);

    // Run up to seq 0x37 with a pending sample, then pulse reset between edges.
    cnt_v = 15'h0120;
    k = 0;
    while (!(m_seq == 8'h37 && m_valid) && k < 400) begin
      cnt_v = cnt_v + 15'd3;
      cycle(1'b1, cnt_v, 1'b0, 1'b0);
      check_model();
      k++;
    end
    check("s6_pre_seq",   32'(bus.seq),   32'h37);
    check("s6_pre_valid", 32'(bus.valid), 32'h1);
    bus.enable = 1'b1; bus.count = 15'h0200; bus.ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("s6_rst_delta",   32'(bus.delta),   32'h0);
    check("s6_rst_seq",     32'(bus.seq),     32'h0);
    check("s6_rst_valid",   32'(bus.valid),   32'h0);
    check("s6_rst_overrun", 32'(bus.overrun), 32'h0);
    #1 reset = 1'b1;
    model_reset();
    cycle(1'b1, 15'h0200, 1'b1, 1'b0);
    for (int c = 0; c < int'(P); c++) cycle(1'b1, 15'h0208, 1'b1, 1'b0);
    check("s6_post_valid", 32'(bus.valid), 32'h1);
    check("s6_post_seq",   32'(bus.seq),   32'd1);
    check("s6_post_delta", 32'(bus.delta), 32'h0008);

    // Randomized run against the reference model.
    cnt_v = 15'h0208;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 31) == 0) cnt_v = 15'($urandom);
      else cnt_v = cnt_v + 15'($urandom_range(0, 40)) - 15'd20;
      cycle($urandom_range(0, 19) != 0, cnt_v, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
